// File: rtl/ed25519_base_scalar_mult.sv
// Ed25519 fixed-base scalar multiplication K*B: MSB-first double-and-add over one
// shared unified point adder, with optional normalisation of the result to Z=1.

module ed25519_point_add (
  input  logic         clk,
  input  logic         srst,
  input  logic [254:0] x1,
  input  logic [254:0] y1,
  input  logic [254:0] t1,
  input  logic [254:0] z1,
  input  logic [254:0] x2,
  input  logic [254:0] y2,
  input  logic [254:0] t2,
  input  logic [254:0] z2,
  input  logic         affine,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [254:0] x3,
  output logic [254:0] y3,
  output logic [254:0] t3,
  output logic [254:0] z3
);
  localparam logic [254:0] P    = '1 - 255'd18;
  localparam logic [254:0] P_M2 = P - 255'd2;
  localparam logic [254:0] K2D  =
    255'd16295367250680780974490674513165176452449235426866156013048779062215315747161;

  function automatic logic [254:0] add_mod(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[254:0];
  endfunction

  function automatic logic [254:0] sub_mod(input logic [254:0] a, input logic [254:0] b);
    logic [255:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + {1'b0, P} - {1'b0, b};
    return s[254:0];
  endfunction

  // 2^255 == 19 (mod p): fold the high half twice, then one conditional subtract.
  function automatic logic [254:0] mul_mod(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] prod;
    logic [260:0] s1;
    logic [255:0] s2;
    prod = {255'd0, a} * {255'd0, b};
    s1   = {6'd0, prod[254:0]} + {6'd0, prod[509:255]} * 261'd19;
    s2   = {1'b0, s1[254:0]} + {250'd0, s1[260:255]} * 256'd19;
    if (s2 >= {1'b0, P}) s2 = s2 - {1'b0, P};
    return s2[254:0];
  endfunction

  typedef enum logic [2:0] {PA_IDLE, PA_MUL, PA_INV, PA_AFF, PA_DONE} pa_state_t;

  pa_state_t    state_reg, state_next;
  logic [3:0]   step_reg;
  logic [7:0]   bit_reg;
  logic         inv_phase_reg;
  logic [254:0] a_reg, b_reg, c_reg, d_reg, inv_reg;
  logic [254:0] x_reg, y_reg, t_reg, z_reg;
  logic [254:0] mul_a, mul_b, mul_p;

  assign mul_p = mul_mod(mul_a, mul_b);
  assign x3 = x_reg;
  assign y3 = y_reg;
  assign t3 = t_reg;
  assign z3 = z_reg;

  always_comb begin
    state_next = state_reg;
    mul_a      = '0;
    mul_b      = '0;
    req_ready  = 1'b0;
    res_valid  = 1'b0;
    case (state_reg)
      PA_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = PA_MUL;
      end
      PA_MUL: begin
        // Unified a=-1 addition, one field multiply per step.
        case (step_reg)
          4'd0: begin mul_a = sub_mod(y1, x1);       mul_b = sub_mod(y2, x2);       end
          4'd1: begin mul_a = add_mod(y1, x1);       mul_b = add_mod(y2, x2);       end
          4'd2: begin mul_a = t1;                    mul_b = t2;                    end
          4'd3: begin mul_a = c_reg;                 mul_b = K2D;                   end
          4'd4: begin mul_a = z1;                    mul_b = z2;                    end
          4'd5: begin mul_a = sub_mod(b_reg, a_reg); mul_b = sub_mod(d_reg, c_reg); end
          4'd6: begin mul_a = add_mod(d_reg, c_reg); mul_b = add_mod(b_reg, a_reg); end
          4'd7: begin mul_a = sub_mod(b_reg, a_reg); mul_b = add_mod(b_reg, a_reg); end
          default: begin mul_a = sub_mod(d_reg, c_reg); mul_b = add_mod(d_reg, c_reg); end
        endcase
        if (step_reg == 4'd8) state_next = affine ? PA_INV : PA_DONE;
      end
      PA_INV: begin
        // Z^(p-2), square-and-multiply from the top exponent bit.
        mul_a = inv_reg;
        mul_b = inv_phase_reg ? z_reg : inv_reg;
        if ((inv_phase_reg || !P_M2[bit_reg]) && bit_reg == 8'd0) state_next = PA_AFF;
      end
      PA_AFF: begin
        case (step_reg)
          4'd0:    begin mul_a = x_reg; mul_b = inv_reg; end
          4'd1:    begin mul_a = y_reg; mul_b = inv_reg; end
          default: begin mul_a = x_reg; mul_b = y_reg;   end
        endcase
        if (step_reg == 4'd2) state_next = PA_DONE;
      end
      default: begin
        res_valid = 1'b1;
        if (res_ready) state_next = PA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg     <= PA_IDLE;
      step_reg      <= '0;
      bit_reg       <= '0;
      inv_phase_reg <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      inv_reg       <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      t_reg         <= '0;
      z_reg         <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        PA_IDLE: step_reg <= '0;
        PA_MUL: begin
          step_reg      <= (step_reg == 4'd8) ? 4'd0 : step_reg + 4'd1;
          inv_reg       <= 255'd1;
          bit_reg       <= 8'd254;
          inv_phase_reg <= 1'b0;
          case (step_reg)
            4'd0:       a_reg <= mul_p;
            4'd1:       b_reg <= mul_p;
            4'd2, 4'd3: c_reg <= mul_p;
            4'd4:       d_reg <= add_mod(mul_p, mul_p);
            4'd5:       x_reg <= mul_p;
            4'd6:       y_reg <= mul_p;
            4'd7:       t_reg <= mul_p;
            default:    z_reg <= mul_p;
          endcase
        end
        PA_INV: begin
          inv_reg <= mul_p;
          if (inv_phase_reg || !P_M2[bit_reg]) begin
            inv_phase_reg <= 1'b0;
            bit_reg       <= bit_reg - 8'd1;
          end else begin
            inv_phase_reg <= 1'b1;
          end
        end
        PA_AFF: begin
          step_reg <= step_reg + 4'd1;
          case (step_reg)
            4'd0: x_reg <= mul_p;
            4'd1: y_reg <= mul_p;
            default: begin
              t_reg <= mul_p;
              z_reg <= 255'd1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

module ed25519_base_scalar_mult (
  input  logic         clk,
  input  logic         rst,
  input  logic [254:0] K,
  input  logic         affine,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic [254:0] px,
  output logic [254:0] py,
  output logic [254:0] pt,
  output logic [254:0] pz,
  output logic         res_valid,
  input  logic         res_ready
);
  localparam logic [254:0] BX =
    255'd15112221349535400772501151409588531511454012693041857206046113283949847762202;
  localparam logic [254:0] BY =
    255'd46316835694926478169428394003475163141307993866256225615783033603165251855960;
  localparam logic [254:0] BT =
    255'd46827403850823179245072216630277197565144205554125654976674165829533817101731;

  typedef enum logic [2:0] {S_IDLE, S_DBL, S_ADD, S_NEXT, S_NORM, S_DONE} state_t;

  state_t       state_reg, state_next;
  logic [254:0] k_reg;
  logic         affine_reg;
  logic [7:0]   i_reg;
  logic         issued_reg;
  logic [254:0] qx_reg, qy_reg, qt_reg, qz_reg;
  logic [254:0] px_reg, py_reg, pt_reg, pz_reg;

  logic         pa_srst, pa_req_valid, pa_req_ready, pa_res_valid, pa_res_ready, pa_affine;
  logic [254:0] pa_x2, pa_y2, pa_t2, pa_z2, pa_x3, pa_y3, pa_t3, pa_z3;

  assign pa_srst   = ~rst;
  assign req_ready = (state_reg == S_IDLE) && rst;
  assign req_busy  = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign res_valid = (state_reg == S_DONE);
  assign px = px_reg;
  assign py = py_reg;
  assign pt = pt_reg;
  assign pz = pz_reg;

  ed25519_point_add u_point_add (
    .clk       (clk),
    .srst      (pa_srst),
    .x1        (qx_reg),
    .y1        (qy_reg),
    .t1        (qt_reg),
    .z1        (qz_reg),
    .x2        (pa_x2),
    .y2        (pa_y2),
    .t2        (pa_t2),
    .z2        (pa_z2),
    .affine    (pa_affine),
    .req_valid (pa_req_valid),
    .req_ready (pa_req_ready),
    .res_valid (pa_res_valid),
    .res_ready (pa_res_ready),
    .x3        (pa_x3),
    .y3        (pa_y3),
    .t3        (pa_t3),
    .z3        (pa_z3)
  );

  always_comb begin
    state_next   = state_reg;
    pa_req_valid = 1'b0;
    pa_res_ready = 1'b0;
    pa_affine    = 1'b0;
    pa_x2        = qx_reg;
    pa_y2        = qy_reg;
    pa_t2        = qt_reg;
    pa_z2        = qz_reg;
    case (state_reg)
      S_IDLE: if (req_valid) state_next = S_DBL;
      S_DBL: begin
        pa_req_valid = !issued_reg;
        pa_res_ready = issued_reg;
        if (issued_reg && pa_res_valid) state_next = k_reg[i_reg] ? S_ADD : S_NEXT;
      end
      S_ADD: begin
        pa_x2        = BX;
        pa_y2        = BY;
        pa_t2        = BT;
        pa_z2        = 255'd1;
        pa_req_valid = !issued_reg;
        pa_res_ready = issued_reg;
        if (issued_reg && pa_res_valid) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (i_reg == 8'd0) state_next = affine_reg ? S_NORM : S_DONE;
        else               state_next = S_DBL;
      end
      S_NORM: begin
        // Adding the identity with affine=1 reuses the adder's inversion path.
        pa_x2        = '0;
        pa_y2        = 255'd1;
        pa_t2        = '0;
        pa_z2        = 255'd1;
        pa_affine    = 1'b1;
        pa_req_valid = !issued_reg;
        pa_res_ready = issued_reg;
        if (issued_reg && pa_res_valid) state_next = S_DONE;
      end
      default: if (res_ready) state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      k_reg      <= '0;
      affine_reg <= 1'b0;
      i_reg      <= '0;
      issued_reg <= 1'b0;
      qx_reg     <= '0;
      qy_reg     <= '0;
      qt_reg     <= '0;
      qz_reg     <= '0;
      px_reg     <= '0;
      py_reg     <= '0;
      pt_reg     <= '0;
      pz_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (pa_req_valid && pa_req_ready) issued_reg <= 1'b1;
      if (pa_res_valid && pa_res_ready) begin
        issued_reg <= 1'b0;
        qx_reg     <= pa_x3;
        qy_reg     <= pa_y3;
        qt_reg     <= pa_t3;
        qz_reg     <= pa_z3;
      end
      case (state_reg)
        S_IDLE: if (req_valid) begin
          k_reg      <= K;
          affine_reg <= affine;
          i_reg      <= 8'd254;
          qx_reg     <= '0;
          qy_reg     <= 255'd1;
          qt_reg     <= '0;
          qz_reg     <= 255'd1;
        end
        S_NEXT: begin
          if (i_reg != 8'd0) begin
            i_reg <= i_reg - 8'd1;
          end else if (!affine_reg) begin
            px_reg <= qx_reg;
            py_reg <= qy_reg;
            pt_reg <= qt_reg;
            pz_reg <= qz_reg;
          end
        end
        S_NORM: if (pa_res_valid && pa_res_ready) begin
          px_reg <= pa_x3;
          py_reg <= pa_y3;
          pt_reg <= pa_t3;
          pz_reg <= pa_z3;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ed25519_base_scalar_mult.sv
// Randomised bench for ed25519_base_scalar_mult against an affine Edwards-law
// reference model evaluated with plain modular arithmetic.

module tb_ed25519_base_scalar_mult;
  localparam logic [254:0] P =
    255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;
  localparam logic [254:0] BX =
    255'd15112221349535400772501151409588531511454012693041857206046113283949847762202;
  localparam logic [254:0] BY =
    255'd46316835694926478169428394003475163141307993866256225615783033603165251855960;
  localparam logic [254:0] BT =
    255'd46827403850823179245072216630277197565144205554125654976674165829533817101731;
  localparam logic [254:0] KX_X =
    255'd17351483335618955898257769922188544065278108135404925499428750032271660309906;
  localparam logic [254:0] KX_Y =
    255'd29738576592467362110154903071697150364418431465120291767221481889329610038128;

  logic         clk = 1'b0;
  logic         rst;
  logic [254:0] K;
  logic         affine;
  logic         req_valid;
  logic         req_ready;
  logic         req_busy;
  logic [254:0] px, py, pt, pz;
  logic         res_valid;
  logic         res_ready;

  int           check_cnt = 0;
  int           err_cnt = 0;
  logic [254:0] d_const;

  always #5 clk = ~clk;

  ed25519_base_scalar_mult dut (
    .clk       (clk),
    .rst       (rst),
    .K         (K),
    .affine    (affine),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_busy  (req_busy),
    .px        (px),
    .py        (py),
    .pt        (pt),
    .pz        (pz),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  task automatic check(input string tag, input logic [254:0] got, input logic [254:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [254:0] fmul(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = ({257'd0, a} * {257'd0, b}) % {257'd0, P};
    return t[254:0];
  endfunction

  function automatic logic [254:0] fadd(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = ({257'd0, a} + {257'd0, b}) % {257'd0, P};
    return t[254:0];
  endfunction

  function automatic logic [254:0] fsub(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = ({257'd0, a} + {257'd0, P} - {257'd0, b}) % {257'd0, P};
    return t[254:0];
  endfunction

  function automatic logic [254:0] finv(input logic [254:0] a);
    logic [254:0] r, e;
    r = 255'd1;
    e = P - 255'd2;
    for (int b = 254; b >= 0; b--) begin
      r = fmul(r, r);
      if (e[b]) r = fmul(r, a);
    end
    return r;
  endfunction

  // Affine twisted Edwards addition (a = -1); both denominators share one inversion.
  task automatic ed_add(input logic [254:0] x1, input logic [254:0] y1,
                        input logic [254:0] x2, input logic [254:0] y2,
                        output logic [254:0] x3, output logic [254:0] y3);
    logic [254:0] m, u, v, iuv;
    m   = fmul(d_const, fmul(fmul(x1, x2), fmul(y1, y2)));
    u   = fadd(255'd1, m);
    v   = fsub(255'd1, m);
    iuv = finv(fmul(u, v));
    x3  = fmul(fadd(fmul(x1, y2), fmul(y1, x2)), fmul(iuv, v));
    y3  = fmul(fadd(fmul(y1, y2), fmul(x1, x2)), fmul(iuv, u));
  endtask

  task automatic ref_mult(input logic [254:0] k, output logic [254:0] rx, output logic [254:0] ry);
    logic [254:0] ax, ay;
    ax = '0;
    ay = 255'd1;
    for (int b = 254; b >= 0; b--) begin
      ed_add(ax, ay, ax, ay, ax, ay);
      if (k[b]) ed_add(ax, ay, BX, BY, ax, ay);
    end
    rx = ax;
    ry = ay;
  endtask

  task automatic check_point(input string tag, input logic aff,
                             input logic [254:0] ox, input logic [254:0] oy,
                             input logic [254:0] ot, input logic [254:0] oz,
                             input logic [254:0] ex, input logic [254:0] ey);
    logic [254:0] zi;
    if (aff) begin
      check({tag, "_x"}, ox, ex);
      check({tag, "_y"}, oy, ey);
      check({tag, "_z"}, oz, 255'd1);
      check({tag, "_t"}, ot, fmul(ex, ey));
    end else begin
      zi = finv(oz);
      check({tag, "_x/z"}, fmul(ox, zi), ex);
      check({tag, "_y/z"}, fmul(oy, zi), ey);
      check({tag, "_xy=tz"}, fmul(ox, oy), fmul(ot, oz));
    end
  endtask

  task automatic send_req(input logic [254:0] k, input logic aff);
    int cyc;
    @(negedge clk);
    K         = k;
    affine    = aff;
    req_valid = 1'b1;
    cyc       = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready", 255'(req_ready), 255'd1);
    @(negedge clk);
    req_valid = 1'b0;
    K         = ~k;
    affine    = ~aff;
    check("busy_after_accept", 255'(req_busy), 255'd1);
    check("no_early_valid", 255'(res_valid), 255'd0);
  endtask

  task automatic do_run(input logic [254:0] k, input logic aff, input int hold,
                        output logic [254:0] ox, output logic [254:0] oy,
                        output logic [254:0] ot, output logic [254:0] oz);
    int cyc;
    send_req(k, aff);
    cyc = 0;
    while (!res_valid && cyc < 9000) begin
      @(negedge clk);
      cyc++;
    end
    check("res_valid_within_budget", 255'(res_valid), 255'd1);
    if (!res_valid) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      ox = '0; oy = '0; ot = '0; oz = '0;
      return;
    end
    check("done_busy", 255'(req_busy), 255'd0);
    check("done_req_ready", 255'(req_ready), 255'd0);
    ox = px; oy = py; ot = pt; oz = pz;
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        req_valid = 1'b1;
        K         = 255'd1;
      end
      @(negedge clk);
      check("hold_valid", 255'(res_valid), 255'd1);
      check("hold_req_ready", 255'(req_ready), 255'd0);
      check("hold_px", px, ox);
      check("hold_py", py, oy);
      check("hold_pt", pt, ot);
      check("hold_pz", pz, oz);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("ack_res_valid", 255'(res_valid), 255'd0);
    check("ack_req_ready", 255'(req_ready), 255'd1);
    $display("TXN k=%h affine=%0d cycles=%0d x=%h y=%h z=%h", k, aff, cyc, ox, oy, oz);
  endtask

  initial begin
    logic [254:0] ox, oy, ot, oz, ex, ey, kr;
    rst       = 1'b0;
    K         = '0;
    affine    = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    d_const   = fsub(255'd0, fmul(255'd121665, finv(255'd121666)));

    repeat (3) @(negedge clk);
    check("rst_res_valid", 255'(res_valid), 255'd0);
    check("rst_busy", 255'(req_busy), 255'd0);
    check("rst_req_ready", 255'(req_ready), 255'd0);
    check("rst_px", px, 255'd0);
    check("rst_py", py, 255'd0);
    check("rst_pz", pz, 255'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 255'(req_ready), 255'd1);

    do_run(255'd1, 1'b1, 0, ox, oy, ot, oz);
    check_point("k1_aff", 1'b1, ox, oy, ot, oz, BX, BY);
    check("k1_aff_bt", ot, BT);
    repeat (3) begin
      @(negedge clk);
      check("k1_valid_once", 255'(res_valid), 255'd0);
    end

    do_run(255'd0, 1'b1, 0, ox, oy, ot, oz);
    check_point("k0_aff", 1'b1, ox, oy, ot, oz, 255'd0, 255'd1);

    do_run(255'd0, 1'b0, 0, ox, oy, ot, oz);
    check("k0_proj_x", ox, 255'd0);
    check("k0_proj_t", ot, 255'd0);
    check("k0_proj_y_eq_z", oy, oz);

    do_run(BX, 1'b1, 20, ox, oy, ot, oz);
    check_point("kbx_aff", 1'b1, ox, oy, ot, oz, KX_X, KX_Y);

    do_run(BX, 1'b0, 0, ox, oy, ot, oz);
    check_point("kbx_proj", 1'b0, ox, oy, ot, oz, KX_X, KX_Y);

    for (int r = 0; r < 2; r++) begin
      kr = '0;
      for (int w = 0; w < 8; w++) kr = {kr[222:0], 32'($urandom())};
      ref_mult(kr, ex, ey);
      do_run(kr, r[0], 3, ox, oy, ot, oz);
      check_point("rand", r[0], ox, oy, ot, oz, ex, ey);
    end

    kr = '0;
    for (int w = 0; w < 8; w++) kr = {kr[222:0], 32'($urandom())};
    send_req(kr, 1'b1);
    repeat (600) @(negedge clk);
    check("mid_busy", 255'(req_busy), 255'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 255'(res_valid), 255'd0);
    check("mid_rst_busy", 255'(req_busy), 255'd0);
    check("mid_rst_req_ready", 255'(req_ready), 255'd0);
    check("mid_rst_px", px, 255'd0);
    check("mid_rst_py", py, 255'd0);
    check("mid_rst_pt", pt, 255'd0);
    check("mid_rst_pz", pz, 255'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 255'(req_ready), 255'd1);

    do_run(255'd1, 1'b1, 0, ox, oy, ot, oz);
    check_point("rerun_k1", 1'b1, ox, oy, ot, oz, BX, BY);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
